card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Dealer side of the card handshake used by the blackjack player FSM. It answers each request_card with one card drawn without replacement from a shoe of NUM_DECKS standard decks. The card is presented on card_value under card_rdy using a four-phase handshake. The block tracks remaining cards per rank, reshuffles on exhaustion or on command, and has a force path so benches can inject deterministic cards.

Parameters:
NUM_DECKS, 1, number of 52-card decks in the shoe (1..8)
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1

Ports:
clock  input  1  all logic on posedge clock; the player FSM uses negedge, so the two interleave
reset  input  1  synchronous, active-high
request_card  input  1  player request; level, four-phase
card_rdy  output  1  card valid; held until request_card drops
card_value  output  4  1=ace, 2..9, 10 for ten/J/Q/K; stable while card_rdy=1
shuffle_req  input  1  level; reshuffle the shoe; honoured only in IDLE
force_en  input  1  at draw time, deliver force_value instead of a deck card
force_value  input  4  forced value; 0 or >10 is delivered as 10
cards_left  output  CLW  cards remaining; CLW = clog2(52*NUM_DECKS+1)
shuffled  output  1  one-cycle pulse when the shoe is refilled

Behaviour:
- Reset (sampled at posedge with reset=1):
  - state=IDLE, card_rdy=0, card_value=0, shuffled=0.
  - Every rank count (ranks 1..13) = 4*NUM_DECKS; cards_left = 52*NUM_DECKS.
  - lfsr = SEED.
  - Reset overrides everything, including mid-PRESENT; card_rdy drops on that edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every non-reset cycle.
- States and transitions:
  - IDLE: card_rdy=0.
    - shuffle_req=1 -> SHUFFLE. This has priority over request_card.
    - Else request_card=1 and cards_left=0 -> SHUFFLE.
    - Else request_card=1 -> DRAW. Latch start rank r = (lfsr[3:0] mod 13)+1.
  - SHUFFLE: one cycle.
    - All counts = 4*NUM_DECKS; cards_left = 52*NUM_DECKS; shuffled=1 on this cycle only.
    - -> IDLE. A still-high request then proceeds to DRAW.
  - DRAW: decision is made on the first DRAW cycle.
    - force_en=1: card_value = force_value (clamped as above); counts and cards_left unchanged; -> PRESENT.
    - Else count[r]>0: card_value = min(r,10); count[r]--, cards_left--; -> PRESENT.
    - Else r = r+1, wrapping 13->1; stay in DRAW. At most 12 extra cycles, since cards_left>0 is guaranteed.
  - PRESENT: card_rdy=1, card_value held.
    - Stay while request_card=1.
    - request_card=0 -> RELEASE.
  - RELEASE: card_rdy=0 for exactly one cycle; -> IDLE. A request high during RELEASE is not served until IDLE.
- Timing:
  - Minimum latency is request high at edge N -> DRAW at N+1 -> card_rdy=1 after edge N+2.
  - After shuffle_req or exhaustion, add 2 cycles.
- shuffle_req and force_en are ignored outside IDLE and DRAW respectively.
- cards_left never underflows; count[r] never decrements below 0.
- card_value retains its last value while card_rdy=0; it is meaningful only with card_rdy=1.

Test Plan:
- Reset, then idle 5 cycles -> card_rdy=0, card_value=0, cards_left=52, shuffled never pulses.
- force_en=1, force_value=1, pulse request via player-style four-phase -> card_rdy high 2 cycles after request; card_value=1 stable until request drops; card_rdy low 1 cycle after drop; cards_left stays 52.
- Request held high 10 cycles after card_rdy -> card_rdy and card_value unchanged; re-raise request during RELEASE -> card_rdy stays low ≥1 cycle before next DRAW.
- 52 unforced draws (NUM_DECKS=1) -> value 10 seen exactly 16 times, values 1..9 exactly 4 times each, cards_left=0; 53rd request -> shuffled pulses once, card delivered, cards_left=51.
- shuffle_req=1 and request_card=1 together in IDLE after 10 draws -> SHUFFLE first (cards_left=52, shuffled=1), then draw -> cards_left=51.
- reset asserted while card_rdy=1 with cards_left=40 -> next edge card_rdy=0, cards_left=52, state IDLE.

Source files
------------

// File: rtl/card_dealer.sv
// Dealer half of the blackjack card handshake: draws cards without replacement
// from a NUM_DECKS shoe and presents each card under a four-phase card_rdy/request_card handshake.
module card_dealer #(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CLW       = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           request_card,
    output logic           card_rdy,
    output logic [3:0]     card_value,
    input  logic           shuffle_req,
    input  logic           force_en,
    input  logic [3:0]     force_value,
    output logic [CLW-1:0] cards_left,
    output logic           shuffled
);

    localparam int CW = $clog2(4 * NUM_DECKS + 1);
    localparam logic [CW-1:0]  RANK_FULL = CW'(4 * NUM_DECKS);
    localparam logic [CLW-1:0] SHOE_FULL = CLW'(52 * NUM_DECKS);
    localparam logic [15:0]    SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [2:0] {
        IDLE,
        SHUFFLE,
        DRAW,
        PRESENT,
        RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_next;
    logic [3:0]       r_rank;
    logic [3:0]       w_start_rank;
    logic [3:0]       w_rank_idx;
    logic [3:0]       w_rank_value;
    logic [3:0]       w_force_clamped;
    logic             w_rank_avail;
    logic [CW-1:0]    r_count [0:12];
    logic [CLW-1:0]   r_cards_left;
    logic [3:0]       r_card_value;
    logic             r_shuffled;

    // Fibonacci LFSR, taps 16,14,13,11; the low nibble seeds the start rank of a draw.
    assign w_lfsr_next     = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_start_rank    = ((r_lfsr[3:0] >= 4'd13) ? (r_lfsr[3:0] - 4'd13) : r_lfsr[3:0]) + 4'd1;
    assign w_rank_idx      = r_rank - 4'd1;
    assign w_rank_avail    = (r_count[w_rank_idx] != '0);
    assign w_rank_value    = (r_rank > 4'd10) ? 4'd10 : r_rank;
    assign w_force_clamped = ((force_value == 4'd0) || (force_value > 4'd10)) ? 4'd10 : force_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (shuffle_req) begin
                    w_next = SHUFFLE;
                end else if (request_card && (r_cards_left == '0)) begin
                    w_next = SHUFFLE;
                end else if (request_card) begin
                    w_next = DRAW;
                end
            end
            SHUFFLE: w_next = IDLE;
            DRAW: begin
                if (force_en || w_rank_avail) begin
                    w_next = PRESENT;
                end
            end
            PRESENT: begin
                if (!request_card) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shoe is refilled on the edge that enters SHUFFLE, so the SHUFFLE cycle already shows a full shoe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr       <= SEED_EFF;
            r_rank       <= 4'd1;
            r_cards_left <= SHOE_FULL;
            r_card_value <= 4'd0;
            r_shuffled   <= 1'b0;
            for (int i = 0; i < 13; i++) begin
                r_count[i] <= RANK_FULL;
            end
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_shuffled <= (w_next == SHUFFLE);
            if (w_next == SHUFFLE) begin
                r_cards_left <= SHOE_FULL;
                for (int i = 0; i < 13; i++) begin
                    r_count[i] <= RANK_FULL;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_next == DRAW) begin
                        r_rank <= w_start_rank;
                    end
                end
                DRAW: begin
                    if (force_en) begin
                        r_card_value <= w_force_clamped;
                    end else if (w_rank_avail) begin
                        r_card_value         <= w_rank_value;
                        r_count[w_rank_idx]  <= r_count[w_rank_idx] - 1'b1;
                        if (r_cards_left != '0) begin
                            r_cards_left <= r_cards_left - 1'b1;
                        end
                    end else begin
                        r_rank <= (r_rank >= 4'd13) ? 4'd1 : (r_rank + 4'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign card_rdy   = (r_state == PRESENT);
    assign card_value = r_card_value;
    assign cards_left = r_cards_left;
    assign shuffled   = r_shuffled;

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer (one deck), driven player-style
// on the falling edge and sampled on the falling edge.
module tb_card_dealer;

    localparam int CLW = 6;

    logic           clock;
    logic           reset;
    logic           request_card;
    logic           card_rdy;
    logic [3:0]     card_value;
    logic           shuffle_req;
    logic           force_en;
    logic [3:0]     force_value;
    logic [CLW-1:0] cards_left;
    logic           shuffled;

    int checkCount;
    int errorCount;
    int hist [0:15];

    card_dealer #(.NUM_DECKS(1), .SEED(16'hACE1)) dut (
        .clock        (clock),
        .reset        (reset),
        .request_card (request_card),
        .card_rdy     (card_rdy),
        .card_value   (card_value),
        .shuffle_req  (shuffle_req),
        .force_en     (force_en),
        .force_value  (force_value),
        .cards_left   (cards_left),
        .shuffled     (shuffled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Full four-phase draw from an idle dealer; returns the card and how many shuffle pulses were seen.
    task automatic applyStimulus(input logic frc, input logic [3:0] fv,
                                 output logic [3:0] val, output int shufPulses);
        bit got;
        got        = 1'b0;
        shufPulses = 0;
        val        = 4'd0;
        force_en    = frc;
        force_value = fv;
        request_card = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            stepCycle();
            if (shuffled) shufPulses++;
            if (card_rdy) got = 1'b1;
        end
        if (!got) checkOutput("rdy_timeout", 0, 1);
        val = card_value;
        request_card = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            stepCycle();
            if (!card_rdy) got = 1'b1;
        end
        if (!got) checkOutput("release_timeout", 0, 1);
        stepCycle();
        force_en = 1'b0;
    endtask

    initial begin
        logic [3:0] v;
        int         sp;
        int         shufSeen;
        bit         stable;
        bit         got;

        checkCount   = 0;
        errorCount   = 0;
        reset        = 1'b1;
        request_card = 1'b0;
        shuffle_req  = 1'b0;
        force_en     = 1'b0;
        force_value  = 4'd0;
        for (int i = 0; i < 16; i++) hist[i] = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Idle after reset
        shufSeen = 0;
        stable   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            if (shuffled) shufSeen++;
            if (card_rdy) stable = 1'b0;
        end
        checkOutput("idle_rdy", int'(stable), 1);
        checkOutput("idle_shuffled", shufSeen, 0);
        checkOutput("reset_value", card_value, 0);
        checkOutput("reset_left", cards_left, 52);

        // Forced ace with latency and hold checks
        force_en     = 1'b1;
        force_value  = 4'd1;
        request_card = 1'b1;
        stepCycle();
        checkOutput("lat_rdy_early", card_rdy, 0);
        stepCycle();
        checkOutput("lat_rdy", card_rdy, 1);
        checkOutput("force_value", card_value, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (!card_rdy || card_value != 4'd1) stable = 1'b0;
        end
        checkOutput("hold_stable", int'(stable), 1);
        checkOutput("force_left", cards_left, 52);
        request_card = 1'b0;
        stepCycle();
        checkOutput("release_rdy", card_rdy, 0);
        request_card = 1'b1;
        stepCycle();
        checkOutput("rerise_idle_rdy", card_rdy, 0);
        stepCycle();
        checkOutput("rerise_draw_rdy", card_rdy, 0);
        stepCycle();
        checkOutput("rerise_rdy", card_rdy, 1);
        checkOutput("rerise_value", card_value, 1);
        request_card = 1'b0;
        stepCycle();
        stepCycle();
        force_en = 1'b0;
        checkOutput("rerise_left", cards_left, 52);

        // Drain the whole deck
        for (int n = 0; n < 52; n++) begin
            applyStimulus(1'b0, 4'd0, v, sp);
            hist[v]++;
        end
        checkOutput("hist_10", hist[10], 16);
        for (int k = 1; k <= 9; k++) begin
            checkOutput($sformatf("hist_%0d", k), hist[k], 4);
        end
        checkOutput("drained_left", cards_left, 0);

        applyStimulus(1'b0, 4'd0, v, sp);
        checkOutput("exhaust_shuffle", sp, 1);
        checkOutput("exhaust_value_ok", int'(v >= 4'd1 && v <= 4'd10), 1);
        checkOutput("exhaust_left", cards_left, 51);

        // Nine more unforced draws brings it to ten since the refill
        for (int n = 0; n < 9; n++) applyStimulus(1'b0, 4'd0, v, sp);
        checkOutput("ten_left", cards_left, 42);

        shuffle_req  = 1'b1;
        request_card = 1'b1;
        stepCycle();
        checkOutput("cmd_shuffled", shuffled, 1);
        checkOutput("cmd_left", cards_left, 52);
        shuffle_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            stepCycle();
            if (card_rdy) got = 1'b1;
        end
        checkOutput("cmd_draw_rdy", int'(got), 1);
        checkOutput("cmd_draw_left", cards_left, 51);
        request_card = 1'b0;
        repeat (3) stepCycle();

        // Reset while a card is presented
        for (int n = 0; n < 10; n++) applyStimulus(1'b0, 4'd0, v, sp);
        checkOutput("pre_reset_left", cards_left, 41);
        request_card = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            stepCycle();
            if (card_rdy) got = 1'b1;
        end
        checkOutput("mid_rdy", int'(got), 1);
        checkOutput("mid_left", cards_left, 40);
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_rdy", card_rdy, 0);
        checkOutput("rst_left", cards_left, 52);
        checkOutput("rst_value", card_value, 0);
        request_card = 1'b0;
        reset = 1'b0;
        stepCycle();

        // Back in IDLE: forced values clamp to ten
        applyStimulus(1'b1, 4'd12, v, sp);
        checkOutput("clamp_12", v, 10);
        applyStimulus(1'b1, 4'd0, v, sp);
        checkOutput("clamp_0", v, 10);
        applyStimulus(1'b1, 4'd9, v, sp);
        checkOutput("force_9", v, 9);
        checkOutput("post_force_left", cards_left, 52);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got 0, expected 1");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
